// File: rtl/hazard_stall_ctrl.sv
// Load-use / memory-freeze stall controller between ID and EX.
// Drives PC/IF/ID hold, ID/EX bubble and EX/MEM hold, plus a saturating stall counter.
module hazard_stall_ctrl #(
    parameter int unsigned REG_W     = 3,
    parameter int unsigned LU_CYCLES = 1,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned ZERO_REG  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_valid,
    input  logic             id_rt_valid,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic             mem_busy,
    input  logic             mem_done,
    input  logic             flush,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_bubble,
    output logic             exmem_hold,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned LU_CNT_W = $clog2(LU_CYCLES) + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        LU_WAIT  = 2'b01,
        MEM_WAIT = 2'b10
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [LU_CNT_W-1:0] r_lu_cnt;
    logic [LU_CNT_W-1:0] w_lu_cnt_next;
    logic [CNT_W-1:0]    r_stall_cnt;

    logic w_rs_hit;
    logic w_rt_hit;
    logic w_zero_kill;
    logic w_hazard;
    logic w_mem_stall;
    logic w_pc_hold;
    logic w_ifid_hold;
    logic w_idex_bubble;
    logic w_exmem_hold;

    // Load-use hazard: EX load writing a register that ID actually reads
    assign w_rs_hit    = id_rs_valid && (id_rs == ex_rd);
    assign w_rt_hit    = id_rt_valid && (id_rt == ex_rd);
    assign w_zero_kill = (ZERO_REG != 0) && (ex_rd == '0);
    assign w_hazard    = ex_mem_read && ex_reg_write && (w_rs_hit || w_rt_hit) && !w_zero_kill;

    // busy together with done is a zero-wait access and never freezes
    assign w_mem_stall = mem_busy && !mem_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_lu_cnt    <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state  <= w_next_state;
            r_lu_cnt <= w_lu_cnt_next;
            if (pc_hold && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_lu_cnt_next = r_lu_cnt;
        w_pc_hold     = 1'b0;
        w_ifid_hold   = 1'b0;
        w_idex_bubble = 1'b0;
        w_exmem_hold  = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_mem_stall) begin
                    w_pc_hold    = 1'b1;
                    w_ifid_hold  = 1'b1;
                    w_exmem_hold = 1'b1;
                    w_next_state = MEM_WAIT;
                end else if (flush) begin
                    w_next_state = IDLE;
                end else if (w_hazard) begin
                    w_pc_hold     = 1'b1;
                    w_ifid_hold   = 1'b1;
                    w_idex_bubble = 1'b1;
                    if (LU_CYCLES > 1) begin
                        w_lu_cnt_next = LU_CNT_W'(LU_CYCLES - 1);
                        w_next_state  = LU_WAIT;
                    end
                end
            end

            LU_WAIT: begin
                if (w_mem_stall) begin
                    // Pending load-use count is dropped; hazard re-evaluated after the freeze
                    w_pc_hold     = 1'b1;
                    w_ifid_hold   = 1'b1;
                    w_exmem_hold  = 1'b1;
                    w_lu_cnt_next = '0;
                    w_next_state  = MEM_WAIT;
                end else begin
                    w_pc_hold     = 1'b1;
                    w_ifid_hold   = 1'b1;
                    w_idex_bubble = 1'b1;
                    if (flush || (r_lu_cnt <= LU_CNT_W'(1))) begin
                        w_lu_cnt_next = '0;
                        w_next_state  = IDLE;
                    end else begin
                        w_lu_cnt_next = r_lu_cnt - LU_CNT_W'(1);
                    end
                end
            end

            MEM_WAIT: begin
                if (mem_done) begin
                    w_next_state = IDLE;
                end else begin
                    w_pc_hold    = 1'b1;
                    w_ifid_hold  = 1'b1;
                    w_exmem_hold = 1'b1;
                end
            end

            default: begin
                w_next_state  = IDLE;
                w_lu_cnt_next = '0;
            end
        endcase
    end

    // Enables are forced low for the whole time reset is held
    assign pc_hold      = rst && w_pc_hold;
    assign ifid_hold    = rst && w_ifid_hold;
    assign idex_bubble  = rst && w_idex_bubble;
    assign exmem_hold   = rst && w_exmem_hold;
    assign state        = r_state;
    assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed scoreboard bench for hazard_stall_ctrl using two parameterisations:
// A (LU_CYCLES=1, ZERO_REG=1, CNT_W=16) and B (LU_CYCLES=3, ZERO_REG=0, CNT_W=4).
module tb_hazard_stall_ctrl;

    typedef struct packed {
        logic [2:0] rs;
        logic       rsv;
        logic [2:0] rt;
        logic       rtv;
        logic [2:0] rd;
        logic       mr;
        logic       rw;
        logic       busy;
        logic       done;
        logic       fl;
    } stim_t;

    typedef struct packed {
        logic [5:0]  o;
        logic [15:0] cnt;
    } exp_t;

    logic  clk;
    logic  rst_n;
    stim_t sa;
    stim_t sb;

    logic        a_pc, a_ifid, a_bub, a_exm;
    logic [1:0]  a_st;
    logic [15:0] a_cnt;
    logic        b_pc, b_ifid, b_bub, b_exm;
    logic [1:0]  b_st;
    logic [3:0]  b_cnt;

    exp_t q_exp[$];
    int   n_checks;
    int   n_err;

    hazard_stall_ctrl #(.REG_W(3), .LU_CYCLES(1), .CNT_W(16), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst_n),
        .id_rs(sa.rs), .id_rt(sa.rt), .id_rs_valid(sa.rsv), .id_rt_valid(sa.rtv),
        .ex_rd(sa.rd), .ex_mem_read(sa.mr), .ex_reg_write(sa.rw),
        .mem_busy(sa.busy), .mem_done(sa.done), .flush(sa.fl),
        .pc_hold(a_pc), .ifid_hold(a_ifid), .idex_bubble(a_bub), .exmem_hold(a_exm),
        .state(a_st), .stall_cycles(a_cnt)
    );

    hazard_stall_ctrl #(.REG_W(3), .LU_CYCLES(3), .CNT_W(4), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst_n),
        .id_rs(sb.rs), .id_rt(sb.rt), .id_rs_valid(sb.rsv), .id_rt_valid(sb.rtv),
        .ex_rd(sb.rd), .ex_mem_read(sb.mr), .ex_reg_write(sb.rw),
        .mem_busy(sb.busy), .mem_done(sb.done), .flush(sb.fl),
        .pc_hold(b_pc), .ifid_hold(b_ifid), .idex_bubble(b_bub), .exmem_hold(b_exm),
        .state(b_st), .stall_cycles(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t hz(input logic [2:0] rd, input logic [2:0] rs);
        stim_t s;
        s     = '0;
        s.rd  = rd;
        s.rs  = rs;
        s.rsv = 1'b1;
        s.mr  = 1'b1;
        s.rw  = 1'b1;
        return s;
    endfunction

    function automatic logic [5:0] obs_o(input bit sel);
        if (sel) return {b_pc, b_ifid, b_bub, b_exm, b_st};
        return {a_pc, a_ifid, a_bub, a_exm, a_st};
    endfunction

    function automatic logic [15:0] obs_c(input bit sel);
        if (sel) return 16'(b_cnt);
        return a_cnt;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock of stimulus on the selected DUT; the other sits idle
    task automatic step(input bit sel, input stim_t s, input logic [5:0] o,
                        input logic [15:0] c, input string tag);
        exp_t e;
        e.o   = o;
        e.cnt = c;
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        if (sel) begin sb = s; sa = '0; end
        else     begin sa = s; sb = '0; end
        #2;
        e = q_exp.pop_front();
        chk({tag, " out"}, 16'(obs_o(sel)), 16'(e.o));
        chk({tag, " cnt"}, obs_c(sel), e.cnt);
    endtask

    // Drop reset mid-cycle while the selected DUT is stalled
    task automatic rst_drop(input bit sel, input logic [5:0] o_pre,
                            input logic [15:0] c_pre, input string tag);
        @(posedge clk);
        #1;
        sa = '0;
        sb = '0;
        #1;
        chk({tag, " pre out"}, 16'(obs_o(sel)), 16'(o_pre));
        chk({tag, " pre cnt"}, obs_c(sel), c_pre);
        rst_n = 1'b0;
        #1;
        chk({tag, " rst out"}, 16'(obs_o(sel)), 16'h0);
        chk({tag, " rst cnt"}, obs_c(sel), 16'h0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        stim_t s;
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        sa       = '0;
        sb       = '0;
        #1;
        chk("reset a out", 16'(obs_o(1'b0)), 16'h0);
        chk("reset a cnt", obs_c(1'b0), 16'h0);
        chk("reset b out", 16'(obs_o(1'b1)), 16'h0);
        chk("reset b cnt", obs_c(1'b1), 16'h0);
        #6;
        rst_n = 1'b1;

        // DUT A: single-cycle load-use
        step(0, hz(3'd3, 3'd3), 6'b111000, 16'd0, "a lu rs");
        step(0, '0,             6'b000000, 16'd1, "a lu release");
        s = hz(3'd3, 3'd1); s.rt = 3'd3;
        step(0, s,              6'b000000, 16'd1, "a rt invalid");
        step(0, hz(3'd0, 3'd0), 6'b000000, 16'd1, "a zero reg");
        s = hz(3'd5, 3'd0); s.rsv = 1'b0; s.rt = 3'd5; s.rtv = 1'b1;
        step(0, s,              6'b111000, 16'd1, "a lu rt");
        step(0, '0,             6'b000000, 16'd2, "a lu rt release");
        s = hz(3'd3, 3'd3); s.rw = 1'b0;
        step(0, s,              6'b000000, 16'd2, "a no regwrite");
        s = hz(3'd3, 3'd3); s.fl = 1'b1;
        step(0, s,              6'b000000, 16'd2, "a flush kills");

        // DUT A: memory freeze beats hazard, then five frozen cycles
        s = hz(3'd3, 3'd3); s.busy = 1'b1;
        step(0, s,              6'b110100, 16'd2, "a busy+hazard");
        step(0, '0,             6'b110110, 16'd3, "a memwait 1");
        step(0, '0,             6'b110110, 16'd4, "a memwait 2");
        step(0, '0,             6'b110110, 16'd5, "a memwait 3");
        step(0, '0,             6'b110110, 16'd6, "a memwait 4");
        s = '0; s.done = 1'b1;
        step(0, s,              6'b000010, 16'd7, "a mem done");
        step(0, '0,             6'b000000, 16'd7, "a back idle");
        s = '0; s.busy = 1'b1; s.done = 1'b1;
        step(0, s,              6'b000000, 16'd7, "a zero wait");
        step(0, '0,             6'b000000, 16'd7, "a zero wait idle");

        // DUT A: flush ignored in MEM_WAIT
        s = '0; s.busy = 1'b1;
        step(0, s,              6'b110100, 16'd7, "a busy 2");
        s = '0; s.fl = 1'b1;
        step(0, s,              6'b110110, 16'd8, "a memwait flush");
        s = '0; s.done = 1'b1;
        step(0, s,              6'b000010, 16'd9, "a done 2");
        step(0, '0,             6'b000000, 16'd9, "a idle 2");

        // DUT A: reset while in MEM_WAIT
        s = '0; s.busy = 1'b1;
        step(0, s,              6'b110100, 16'd9, "a busy 3");
        rst_drop(0, 6'b110110, 16'd10, "a rst memwait");

        // DUT B: three-cycle load-use, zero register not special here
        step(1, hz(3'd0, 3'd0), 6'b111000, 16'd0, "b lu3 c0");
        step(1, '0,             6'b111001, 16'd1, "b lu3 c1");
        step(1, '0,             6'b111001, 16'd2, "b lu3 c2");
        step(1, '0,             6'b000000, 16'd3, "b lu3 done");

        // DUT B: flush in second stall cycle
        step(1, hz(3'd3, 3'd3), 6'b111000, 16'd3, "b fl c0");
        s = '0; s.fl = 1'b1;
        step(1, s,              6'b111001, 16'd4, "b fl c1");
        step(1, '0,             6'b000000, 16'd5, "b fl idle");

        // DUT B: memory freeze preempts LU_WAIT
        step(1, hz(3'd3, 3'd3), 6'b111000, 16'd5, "b pre c0");
        s = '0; s.busy = 1'b1;
        step(1, s,              6'b110101, 16'd6, "b lu busy");
        s = '0; s.done = 1'b1;
        step(1, s,              6'b000010, 16'd7, "b lu done");
        step(1, '0,             6'b000000, 16'd7, "b lu idle");

        // DUT B: reset while in LU_WAIT
        step(1, hz(3'd3, 3'd3), 6'b111000, 16'd7, "b rst c0");
        rst_drop(1, 6'b111001, 16'd8, "b rst luwait");

        // DUT B: continuous hazard saturates 4-bit counter
        for (int i = 0; i < 20; i++) begin
            step(1, hz(3'd3, 3'd3), {4'b1110, (i % 3 == 0) ? 2'b00 : 2'b01},
                 16'((i < 15) ? i : 15), "b sat");
        end
        step(1, '0, 6'b111001, 16'd15, "b sat tail");
        step(1, '0, 6'b000000, 16'd15, "b sat hold");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Parametrised successor to the pipeline's combinational load-use stall/bubble logic.
- Sits between ID and EX. Detects load-use hazards with source-valid qualification and holds the pipe for a configurable number of cycles (multi-cycle load latency).
- Freezes the whole pipeline while the cache reports busy, and cancels pending stalls on a branch/jump flush.
- Emits hold/bubble enables to the PC, IF/ID, ID/EX and EX/MEM registers, plus a saturating stall-cycle performance counter.

Parameters:
- REG_W, 3, register-specifier width.
- LU_CYCLES, 1, load-use stall length in cycles (>=1).
- CNT_W, 16, width of the stall performance counter.
- ZERO_REG, 0, when 1, register 0 is hardwired and never creates a hazard.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- id_rs  in  REG_W  ID-stage source register 1 (Instr[10:8]).
- id_rt  in  REG_W  ID-stage source register 2 (Instr[7:5]).
- id_rs_valid  in  1  ID instruction actually reads id_rs.
- id_rt_valid  in  1  ID instruction actually reads id_rt.
- ex_rd  in  REG_W  EX-stage destination register.
- ex_mem_read  in  1  EX instruction is a load.
- ex_reg_write  in  1  EX instruction writes a register.
- mem_busy  in  1  cache miss or memory access outstanding (I or D side).
- mem_done  in  1  one-cycle pulse: outstanding memory access completes.
- flush  in  1  EX-resolved branch/jump redirect; kills IF and ID.
- pc_hold  out  1  PC register keeps its value.
- ifid_hold  out  1  IF/ID register keeps its value.
- idex_bubble  out  1  ID/EX loads a NOP (all control bits and data cleared to 0).
- exmem_hold  out  1  EX/MEM and MEM/WB registers keep their values.
- state  out  2  FSM state, for debug.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_hold=1.

Behaviour:
- FSM states: IDLE=2'b00, LU_WAIT=2'b01, MEM_WAIT=2'b10. Encoding 2'b11 is unused and recovers to IDLE on the next clock.
- Reset (rst=0, asynchronous): state=IDLE, counters=0, stall_cycles=0. All hold/bubble outputs are 0 while rst=0.
- Hazard term, combinational: ex_mem_read & ex_reg_write & ((id_rs_valid & id_rs==ex_rd) | (id_rt_valid & id_rt==ex_rd)) & !(ZERO_REG & ex_rd==0).
- Outputs are combinational from state and current inputs, so a stall takes effect in the same cycle a hazard is detected.
- Priority, highest first: mem_busy, then flush, then hazard.

IDLE:
- mem_busy=1: pc_hold=ifid_hold=exmem_hold=1, idex_bubble=0 (freeze, not bubble). Next state MEM_WAIT.
- else flush=1: no holds, idex_bubble=0. Stay IDLE. Flush kills the hazard.
- else hazard=1: pc_hold=ifid_hold=idex_bubble=1, exmem_hold=0. If LU_CYCLES>1, load lu_cnt=LU_CYCLES-1 and go to LU_WAIT; else stay IDLE.
- else: all outputs 0.

LU_WAIT:
- Asserts pc_hold=ifid_hold=idex_bubble=1 and decrements lu_cnt.
- Returns to IDLE in the cycle lu_cnt reaches 0. The cycle after that is a normal IDLE evaluation, so a re-detected hazard stalls again.
- flush=1: next state IDLE and lu_cnt is cleared. Holds/bubble are still asserted in the flush cycle.
- mem_busy=1 takes priority: freeze outputs as in IDLE, go to MEM_WAIT, and discard lu_cnt (the load-use hazard is re-evaluated afterwards).

MEM_WAIT:
- Asserts pc_hold=ifid_hold=exmem_hold=1 with idex_bubble=0 while mem_done=0.
- In the mem_done=1 cycle, all holds are 0 and next state is IDLE.
- flush is ignored in MEM_WAIT; the requester must re-present it.
- mem_busy and mem_done asserted together in IDLE: treated as a zero-wait access, so no stall and state stays IDLE.

stall_cycles:
- Increments on every rising clk edge where pc_hold=1.
- Saturates at all-ones and never wraps.

General:
- Reset asserted mid-stall forces IDLE immediately.
- Widths: ex_rd, id_rs and id_rt are compared at the full REG_W bits.
- lu_cnt width is clog2(LU_CYCLES)+1.

Test Plan:
- LW r3 in EX (ex_mem_read=1, ex_reg_write=1, ex_rd=3), ID reads id_rs=3 valid, LU_CYCLES=1 -> one cycle of pc_hold=ifid_hold=idex_bubble=1; released next cycle; stall_cycles=1.
- Same hazard with id_rt=3 but id_rt_valid=0 -> no stall. With ZERO_REG=1, ex_rd=0 and id_rs=0 valid -> no stall.
- LU_CYCLES=3, hazard -> holds for exactly 3 cycles (state 00,01,01 then 00); stall_cycles=3. Flush in the second cycle -> holds for 2 cycles, then IDLE.
- mem_busy pulse, then mem_done 5 cycles later -> freeze (exmem_hold=1, idex_bubble=0) for 5 cycles; in the mem_done cycle all outputs=0; state returns to 00.
- mem_busy and hazard in the same cycle -> freeze wins (idex_bubble=0), state MEM_WAIT.
- Drop rst in LU_WAIT and in MEM_WAIT -> outputs 0 and state=00 without a clock edge.
- CNT_W=4, 20 stall cycles -> stall_cycles saturates at 4'hF.
